// File: rtl/square_game_ctrl.sv
// Game-flow controller for the square dodging game: start/collision handling,
// scoring, lives and the post-hit blink window, all outputs registered.
module square_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SCORE_FRAMES = 60,
  parameter int HIT_FRAMES   = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_start,
  input  logic [11:0] i_px1,
  input  logic [11:0] i_px2,
  input  logic [11:0] i_py1,
  input  logic [11:0] i_py2,
  input  logic [11:0] i_ex1,
  input  logic [11:0] i_ex2,
  input  logic [11:0] i_ey1,
  input  logic [11:0] i_ey2,
  output logic        o_animate,
  output logic        o_sq_rst,
  output logic [1:0]  o_state,
  output logic [7:0]  o_score,
  output logic [1:0]  o_lives,
  output logic        o_flash
);

  localparam int MAXF = (SCORE_FRAMES > HIT_FRAMES) ? SCORE_FRAMES : HIT_FRAMES;
  localparam int CW   = ($clog2(MAXF + 1) > 4) ? $clog2(MAXF + 1) : 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3} state_t;

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt, w_ncnt;
  logic [7:0]      r_score, w_nscore;
  logic [1:0]      r_lives, w_nlives;
  logic            r_animate, r_sq_rst, r_flash, w_nsq_rst;
  logic            r_sync1, r_sync2, r_prev, r_fill, r_armed;
  logic            w_start_ev, w_coll;

  // r_armed only sets after a genuine post-reset low sample, so a button held
  // through reset has to be released before it can start a game.
  assign w_start_ev = r_sync2 & ~r_prev & r_armed;
  assign w_coll = (i_px1 < i_ex2) && (i_ex1 < i_px2) && (i_py1 < i_ey2) && (i_ey1 < i_py2);

  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_nscore  = r_score;
    w_nlives  = r_lives;
    w_nsq_rst = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_nstate  = S_PLAY;
          w_nlives  = 2'(LIVES);
          w_nscore  = 8'd0;
          w_ncnt    = '0;
          w_nsq_rst = 1'b1;
        end
      end
      S_PLAY: begin
        if (i_ani_stb) begin
          if (w_coll) begin
            w_nlives = r_lives - 2'd1;
            w_ncnt   = '0;
            w_nstate = (r_lives == 2'd1) ? S_OVER : S_HIT;
          end else if (r_cnt == CW'(SCORE_FRAMES - 1)) begin
            w_ncnt = '0;
            if (r_score != 8'hFF) w_nscore = r_score + 8'd1;
          end else begin
            w_ncnt = r_cnt + CW'(1);
          end
        end
      end
      S_HIT: begin
        if (i_ani_stb) begin
          if (r_cnt == CW'(HIT_FRAMES - 1)) begin
            w_ncnt    = '0;
            w_nsq_rst = 1'b1;
            w_nstate  = S_PLAY;
          end else begin
            w_ncnt = r_cnt + CW'(1);
          end
        end
      end
      S_OVER: begin
        if (w_start_ev) w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_score   <= 8'd0;
      r_lives   <= 2'd0;
      r_animate <= 1'b0;
      r_sq_rst  <= 1'b0;
      r_flash   <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_fill    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= i_start;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_fill    <= 1'b1;
      if (r_fill && !r_sync1) r_armed <= 1'b1;
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_score   <= w_nscore;
      r_lives   <= w_nlives;
      r_animate <= (w_nstate == S_PLAY);
      r_sq_rst  <= w_nsq_rst;
      r_flash   <= (w_nstate == S_HIT) && !w_ncnt[3];
    end
  end

  assign o_state   = r_state;
  assign o_score   = r_score;
  assign o_lives   = r_lives;
  assign o_animate = r_animate;
  assign o_sq_rst  = r_sq_rst;
  assign o_flash   = r_flash;

endmodule

// File: tb/tb_square_game_ctrl.sv
// Bench for square_game_ctrl: game-rule model checked every cycle, directed
// scenarios with literal expectations, and a randomized play phase.
module tb_square_game_ctrl;

  localparam int LIVES = 3, SF = 60, HF = 60;

  logic        i_clk = 1'b0, i_rst = 1'b0, i_ani_stb = 1'b0, i_start = 1'b0;
  logic [11:0] i_px1 = '0, i_px2 = '0, i_py1 = '0, i_py2 = '0;
  logic [11:0] i_ex1 = '0, i_ex2 = '0, i_ey1 = '0, i_ey2 = '0;
  logic        o_animate, o_sq_rst, o_flash;
  logic [1:0]  o_state, o_lives;
  logic [7:0]  o_score;

  square_game_ctrl #(.LIVES(LIVES), .SCORE_FRAMES(SF), .HIT_FRAMES(HF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_start(i_start),
    .i_px1(i_px1), .i_px2(i_px2), .i_py1(i_py1), .i_py2(i_py2),
    .i_ex1(i_ex1), .i_ex2(i_ex2), .i_ey1(i_ey1), .i_ey2(i_ey2),
    .o_animate(o_animate), .o_sq_rst(o_sq_rst), .o_state(o_state),
    .o_score(o_score), .o_lives(o_lives), .o_flash(o_flash)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game-rule model: 0 idle, 1 play, 2 hit, 3 over; frames counts strobes in the current phase.
  int m_state = 0, m_score = 0, m_lives = 0, m_frames = 0, m_sqrst = 0;
  bit m_valid = 0;
  bit hist[$];

  function automatic bit overlap();
    return (int'(i_px1) < int'(i_ex2)) && (int'(i_ex1) < int'(i_px2)) &&
           (int'(i_py1) < int'(i_ey2)) && (int'(i_ey1) < int'(i_py2));
  endfunction

  always @(posedge i_clk) begin
    bit ev;
    if (i_rst) begin
      m_state = 0; m_score = 0; m_lives = 0; m_frames = 0; m_sqrst = 0;
      hist.delete();
      m_valid = 1;
    end else begin
      // a press is seen two edges after its first high sample, preceded by a real low sample
      ev = (hist.size() >= 3) && hist[hist.size()-2] && !hist[hist.size()-3];
      hist.push_back(i_start);
      if (hist.size() > 8) void'(hist.pop_front());
      m_sqrst = 0;
      if (m_state == 0 && ev) begin
        m_state = 1; m_lives = LIVES; m_score = 0; m_frames = 0; m_sqrst = 1;
      end else if (m_state == 1 && i_ani_stb) begin
        if (overlap()) begin
          m_lives = m_lives - 1; m_frames = 0;
          m_state = (m_lives == 0) ? 3 : 2;
        end else begin
          m_frames++;
          if (m_frames == SF) begin
            m_frames = 0;
            if (m_score < 255) m_score++;
          end
        end
      end else if (m_state == 2 && i_ani_stb) begin
        m_frames++;
        if (m_frames == HF) begin m_frames = 0; m_state = 1; m_sqrst = 1; end
      end else if (m_state == 3 && ev) begin
        m_state = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      chk("state", o_state, m_state);
      chk("score", o_score, m_score);
      chk("lives", o_lives, m_lives);
      chk("animate", o_animate, m_state == 1);
      chk("sq_rst", o_sq_rst, m_sqrst);
      chk("flash", o_flash, (m_state == 2) && ((m_frames / 8) % 2 == 0));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; cyc(2); i_rst = 1'b0; cyc(3);
  endtask

  task automatic press();
    i_start = 1'b1; cyc(3); i_start = 1'b0; cyc(3);
  endtask

  task automatic strobes(input int n);
    i_ani_stb = 1'b1; cyc(n); i_ani_stb = 1'b0;
  endtask

  task automatic set_pos(input int p1, input int p2, input int e1, input int e2);
    i_px1 = 12'(p1); i_px2 = 12'(p2); i_py1 = 12'(p1); i_py2 = 12'(p2);
    i_ex1 = 12'(e1); i_ex2 = 12'(e2); i_ey1 = 12'(e1); i_ey2 = 12'(e2);
  endtask

  initial begin
    set_pos(0, 20, 500, 520);
    cyc(1);
    do_reset();
    chk("lit_reset_state", o_state, 0);
    chk("lit_reset_lives", o_lives, 0);

    // start latency: high at edge N, PLAY at edge N+2
    i_start = 1'b1; cyc(2);
    chk("lit_start_n1", o_state, 0);
    cyc(1);
    chk("lit_start_n2", o_state, 1);
    chk("lit_start_sqrst", o_sq_rst, 1);
    chk("lit_start_lives", o_lives, 3);
    chk("lit_start_anim", o_animate, 1);
    cyc(1);
    chk("lit_sqrst_pulse", o_sq_rst, 0);
    i_start = 1'b0; cyc(3);

    strobes(180); cyc(1);
    chk("lit_score3", o_score, 3);

    set_pos(100, 140, 140, 180);
    strobes(1); cyc(1);
    chk("lit_touch_lives", o_lives, 3);
    chk("lit_touch_state", o_state, 1);

    set_pos(100, 140, 139, 180);
    strobes(1);
    chk("lit_hit_state", o_state, 2);
    chk("lit_hit_lives", o_lives, 2);
    chk("lit_hit_flash0", o_flash, 1);
    set_pos(0, 20, 500, 520);
    strobes(8);
    chk("lit_flash8", o_flash, 0);
    strobes(8);
    chk("lit_flash16", o_flash, 1);
    strobes(44);
    chk("lit_hit_done", o_state, 1);
    chk("lit_hit_sqrst", o_sq_rst, 1);
    cyc(2);

    // randomized play with occasional presses
    for (int i = 0; i < 4000; i++) begin
      int e1;
      e1 = int'($urandom_range(60, 200));
      set_pos(100, 140, e1, e1 + 40);
      i_ani_stb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) i_start = ~i_start;
      cyc(1);
    end
    i_ani_stb = 1'b0; i_start = 1'b0; cyc(4);

    // game over with a held score, then restart via IDLE
    do_reset(); press();
    set_pos(0, 20, 500, 520);
    strobes(120);
    set_pos(100, 140, 139, 180);
    for (int i = 0; i < 400 && m_state != 3; i++) strobes(1);
    cyc(1);
    chk("lit_over_state", o_state, 3);
    chk("lit_over_lives", o_lives, 0);
    chk("lit_over_score", o_score, 2);
    strobes(5); cyc(1);
    chk("lit_over_hold", o_score, 2);
    press();
    chk("lit_over_idle", o_state, 0);
    chk("lit_idle_score", o_score, 2);
    press();
    chk("lit_restart_state", o_state, 1);
    chk("lit_restart_lives", o_lives, 3);
    chk("lit_restart_score", o_score, 0);

    // score saturation
    set_pos(0, 20, 500, 520);
    strobes(255 * SF + 2 * SF); cyc(1);
    chk("lit_score_sat", o_score, 255);

    // reset in the middle of HIT with the button held across it
    do_reset(); press();
    set_pos(100, 140, 139, 180);
    strobes(1);
    set_pos(0, 20, 500, 520);
    strobes(30);
    i_start = 1'b1; cyc(2);
    i_rst = 1'b1; cyc(1);
    chk("lit_mrst_state", o_state, 0);
    chk("lit_mrst_out", {o_animate, o_sq_rst, o_flash, o_lives, o_score}, 0);
    i_rst = 1'b0; cyc(10);
    chk("lit_held_idle", o_state, 0);
    i_start = 1'b0; cyc(3);
    press();
    chk("lit_repress", o_state, 1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/square_game_ctrl.md
SQUARE_GAME_CTRL -- requirements
Module: square_game_ctrl

Interface
REQ-001 Parameters SHALL be: LIVES, default 3, lives granted at game start (1-3); SCORE_FRAMES, default 60, frame strobes per score point (>=1); HIT_FRAMES, default 60, frame strobes spent in HIT (>=1).
REQ-002 Port `i_clk`, input, width 1: base clock; the only clock.
REQ-003 Port `i_rst`, input, width 1: reset; synchronous, active-high.
REQ-004 Port `i_ani_stb`, input, width 1: one-cycle frame strobe.
REQ-005 Port `i_start`, input, width 1: asynchronous start button, level.
REQ-006 Ports `i_px1`, `i_px2`, `i_py1`, `i_py2`, input, 12 bits each: player square left/right/top/bottom edges.
REQ-007 Ports `i_ex1`, `i_ex2`, `i_ey1`, `i_ey2`, input, 12 bits each: enemy square left/right/top/bottom edges.
REQ-008 Port `o_animate`, output, width 1: enable for the square movement datapath.
REQ-009 Port `o_sq_rst`, output, width 1: one-cycle pulse that returns the square to its start position.
REQ-010 Port `o_state`, output, 2 bits: IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-011 Port `o_score`, output, 8 bits: score.
REQ-012 Port `o_lives`, output, 2 bits: remaining lives.
REQ-013 Port `o_flash`, output, width 1: blink control for the player square during HIT.

Function
REQ-014 `i_start` SHALL pass through a 2-flop synchronizer; a start event is a rising edge of the synchronized level (one-cycle pulse).
REQ-015 Start latency: `i_start` first sampled high at clock edge N SHALL produce the resulting state change at edge N+2.
REQ-016 Collision SHALL be the strict overlap test: px1<ex2 AND ex1<px2 AND py1<ey2 AND ey1<py2, as 12-bit unsigned compares; touching edges are not a collision.
REQ-017 Collision SHALL be evaluated only in PLAY, only on cycles with `i_ani_stb`=1.
REQ-018 IDLE behaviour:
- `o_animate`=0.
- On a start event: go to PLAY, load lives=LIVES, clear score, clear the frame counter, and pulse `o_sq_rst` for one cycle.
REQ-019 PLAY: `o_animate`=1.
REQ-020 PLAY, strobe with collision:
- Decrement lives.
- Clear the frame counter.
- If lives was 1: go to OVER (lives=0).
- Otherwise: go to HIT.
REQ-021 PLAY, strobe without collision:
- Increment the frame counter.
- When it reaches SCORE_FRAMES: clear it and increment score, saturating at 255.
REQ-022 On a strobe with collision, the collision SHALL take priority and the score SHALL NOT increment on that strobe.
REQ-023 PLAY SHALL ignore start events.
REQ-024 HIT behaviour:
- `o_animate`=0.
- The frame counter counts strobes.
- After HIT_FRAMES strobes: clear the counter, pulse `o_sq_rst` for one cycle, and return to PLAY.
- Start events are ignored.
REQ-025 `o_flash` SHALL be 1 in HIT when counter bit 3 = 0, 0 when bit 3 = 1, and 0 in all other states.
REQ-026 OVER behaviour:
- `o_animate`=0.
- Score and lives are held.
- A start event goes to IDLE with score, lives and counter unchanged until the next game start.
REQ-027 All outputs SHALL be registered; `o_sq_rst` SHALL be high for exactly one cycle per transition into PLAY.
REQ-028 Without `i_ani_stb`, no counter, score or lives change SHALL occur and the only permitted state change is via a start event.

Reset
REQ-029 When `i_rst`=1 at a clock edge, the block SHALL take these values at that edge, overriding any in-progress operation:
- state=IDLE, `o_animate`=0, `o_sq_rst`=0.
- `o_score`=0, `o_lives`=0, `o_flash`=0.
- Frame counter=0, synchronizer flops=0.
REQ-030 A start held high through reset release SHALL NOT produce a start event until it falls and rises again.

Verification
REQ-031 Start: `i_start` rises in IDLE -> `o_state`=1 at the 2nd following edge, `o_sq_rst` one-cycle pulse, `o_lives`=3, `o_score`=0, `o_animate`=1.
REQ-032 Scoring: PLAY, no overlap, 180 strobes -> `o_score`=3; from `o_score`=255, further strobes keep it at 255.
REQ-033 Hit: overlap (p=100..140, e=139..180 on both axes) on a strobe with lives=3 -> state HIT, lives=2, `o_flash`=1 for strobes 0-7 and 0 for 8-15; after 60 strobes, PLAY plus an `o_sq_rst` pulse.
REQ-034 Edge touch: px2=ex1=140 -> no collision, lives unchanged.
REQ-035 Game over: collision with lives=1 -> OVER, lives=0, score held; a start event -> IDLE; a second start event -> PLAY with lives=3, score=0.
REQ-036 Mid-operation reset: `i_rst` asserted in HIT at counter=30 -> next edge IDLE, all outputs 0; `i_start` held high across reset -> stays IDLE until the button is re-pressed.
